// File: rtl/plotter_pkg.sv
// plotter_pkg: types shared by the plotter glyph path.
//   coord_t   - 8-bit unsigned plotter coordinate
//   seg_t     - one stroke segment as stored in the glyph ROM
//   state_t   - stroke_sequencer states (ST_PAUSE only with STROKE_SEQ_PAUSE_EN)
//   SEG_IDX_W - width of the ROM segment index
package plotter_pkg;

  localparam int SEG_IDX_W = 5;

  typedef logic [7:0] coord_t;

  typedef struct packed {
    coord_t sx;
    coord_t sy;
    coord_t ex;
    coord_t ey;
    logic   pen;
  } seg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PEN,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
`ifdef STROKE_SEQ_PAUSE_EN
    , ST_PAUSE
`endif
  } state_t;

endpackage

// File: rtl/pen_settle_timer.sv
// pen_settle_timer: down-counter for the pen-settle delay.
//   clk, rst_n - clock, synchronous active-low reset
//   load       - load PEN_SETTLE-1 (takes priority over en)
//   en         - decrement while non-zero
//   zero       - counter is at 0
module pen_settle_timer
  import plotter_pkg::*;
#(
  parameter int PEN_SETTLE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  // Keep at least one bit so PEN_SETTLE=1 still elaborates.
  localparam int W = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= W'(PEN_SETTLE - 1);
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stroke_sequencer.sv
// stroke_sequencer: walks the stroke ROM of the selected digit one segment at
// a time, issuing each segment as a move command and driving the pen, with a
// settle delay after every pen change.
//   clk, rst_n            - clock, synchronous active-low reset
//   start, digit          - draw request (accepted in IDLE only)
//   abort                 - cancel current glyph, back to IDLE without done
//   pause                 - hold between segments (STROKE_SEQ_PAUSE_EN only)
//   glyph_sel, rom_idx,
//   rom_en, rom_*         - ROM address/enable and combinational ROM data
//   cmd_valid/ready,cmd_* - move command handshake and coordinates
//   move_done             - motion engine finished the accepted move
//   pen_out               - pen actuator (1 = down)
//   busy, done, err       - status; err is sticky until the next start
// Optional feature macro: STROKE_SEQ_PAUSE_EN
module stroke_sequencer
  import plotter_pkg::*;
#(
  parameter int MAX_SEGS   = 32,
  parameter int PEN_SETTLE = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           digit,
  input  logic                 abort,
`ifdef STROKE_SEQ_PAUSE_EN
  input  logic                 pause,
`endif
  output logic [3:0]           glyph_sel,
  output logic [SEG_IDX_W-1:0] rom_idx,
  output logic                 rom_en,
  input  logic [7:0]           rom_sx,
  input  logic [7:0]           rom_sy,
  input  logic [7:0]           rom_ex,
  input  logic [7:0]           rom_ey,
  input  logic                 rom_pen,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_sx,
  output logic [7:0]           cmd_sy,
  output logic [7:0]           cmd_ex,
  output logic [7:0]           cmd_ey,
  input  logic                 move_done,
  output logic                 pen_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(MAX_SEGS - 1);

  state_t state, state_nxt;
  seg_t   seg;
  logic   accept, inc_idx, set_err, settle_zero, terminal;

  // Index 0 is never terminal, so a glyph may start at the origin.
  assign terminal = (rom_idx != '0) && !seg.pen && (seg.ex == '0) && (seg.ey == '0);

  pen_settle_timer #(.PEN_SETTLE(PEN_SETTLE)) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == ST_FETCH),
    .en   (state == ST_PEN),
    .zero (settle_zero)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    inc_idx   = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE:  if (start) begin
                  accept    = 1'b1;
                  state_nxt = ST_FETCH;
                end
      // ROM data is live this cycle; compare it directly with the pen.
      ST_FETCH: state_nxt = (rom_pen != pen_out) ? ST_PEN : ST_ISSUE;
      ST_PEN:   if (settle_zero) state_nxt = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (move_done) begin
                  if (terminal) begin
                    state_nxt = ST_FIN;
                  end else if (rom_idx == LAST_IDX) begin
                    set_err   = 1'b1;
                    state_nxt = ST_FIN;
                  end else begin
                    // Index advances here; a pause only delays the fetch.
                    inc_idx   = 1'b1;
`ifdef STROKE_SEQ_PAUSE_EN
                    state_nxt = pause ? ST_PAUSE : ST_FETCH;
`else
                    state_nxt = ST_FETCH;
`endif
                  end
                end
`ifdef STROKE_SEQ_PAUSE_EN
      ST_PAUSE: if (!pause) state_nxt = ST_FETCH;
`endif
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Abort wins over every handshake in the same cycle.
    if (abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      inc_idx   = 1'b0;
      set_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seg       <= '0;
      glyph_sel <= '0;
      rom_idx   <= '0;
      pen_out   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        glyph_sel <= digit;
        rom_idx   <= '0;
        err       <= 1'b0;
      end else if (inc_idx) begin
        rom_idx <= rom_idx + 1'b1;
      end
      if (set_err) err <= 1'b1;
      if (state == ST_FETCH) seg <= '{rom_sx, rom_sy, rom_ex, rom_ey, rom_pen};
      if (state_nxt == ST_IDLE || state_nxt == ST_FIN)
        pen_out <= 1'b0;
      else if (state == ST_FETCH && state_nxt == ST_PEN)
        pen_out <= rom_pen;
    end
  end

  assign rom_en    = (state == ST_FETCH);
  assign cmd_valid = (state == ST_ISSUE) && !abort;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN) && !abort;
  assign cmd_sx    = seg.sx;
  assign cmd_sy    = seg.sy;
  assign cmd_ex    = seg.ex;
  assign cmd_ey    = seg.ey;

endmodule

// File: tb/tb_stroke_sequencer.sv
// tb_stroke_sequencer: two sequencers (MAX_SEGS 32 and 4, PEN_SETTLE 4)
// share one stimulus set; `sel` picks which one receives start and is
// observed. Expected commands, latencies and err come from walking the
// bench's ROM array with the glyph rules.
module tb_stroke_sequencer;

  localparam int P    = 4;
  localparam int MS_A = 32;
  localparam int MS_B = 4;

  typedef struct packed {
    logic [7:0] sx, sy, ex, ey;
    logic       pen;
  } sg_t;

  typedef struct {
    logic [3:0] dg;
    bit         b;
    int         rdy, dly, hold, abrt, pz, n, e;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 0, abort = 0, cmd_ready = 0, move_done = 0, sel = 0;
  logic [3:0] digit = 0;
`ifdef STROKE_SEQ_PAUSE_EN
  logic       pause = 0;
`endif

  logic [3:0] gs [2];
  logic [4:0] ix [2];
  logic [7:0] csx [2], csy [2], cex [2], cey [2];
  logic       re [2], cv [2], pn [2], bz [2], dn [2], er [2];

  sg_t rom [16][32];
  sg_t rs;

  always_comb begin
    rs = '0;
    if (re[sel]) rs = rom[gs[sel]][ix[sel]];
  end

  for (genvar k = 0; k < 2; k++) begin : g_dut
    stroke_sequencer #(.MAX_SEGS(k == 0 ? MS_A : MS_B), .PEN_SETTLE(P)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start && (int'(sel) == k)),
      .digit    (digit),
      .abort    (abort),
`ifdef STROKE_SEQ_PAUSE_EN
      .pause    (pause),
`endif
      .glyph_sel(gs[k]),
      .rom_idx  (ix[k]),
      .rom_en   (re[k]),
      .rom_sx   (rs.sx),
      .rom_sy   (rs.sy),
      .rom_ex   (rs.ex),
      .rom_ey   (rs.ey),
      .rom_pen  (rs.pen),
      .cmd_valid(cv[k]),
      .cmd_ready(cmd_ready),
      .cmd_sx   (csx[k]),
      .cmd_sy   (csy[k]),
      .cmd_ex   (cex[k]),
      .cmd_ey   (cey[k]),
      .move_done(move_done),
      .pen_out  (pn[k]),
      .busy     (bz[k]),
      .done     (dn[k]),
      .err      (er[k])
    );
  end

  logic [3:0]  o_gs;
  logic [4:0]  o_ix;
  logic [31:0] o_cmd;
  logic        o_re, o_cv, o_pen, o_busy, o_done, o_err;
  assign o_gs   = gs[sel];
  assign o_ix   = ix[sel];
  assign o_cmd  = {csx[sel], csy[sel], cex[sel], cey[sel]};
  assign o_re   = re[sel];
  assign o_cv   = cv[sel];
  assign o_pen  = pn[sel];
  assign o_busy = bz[sel];
  assign o_done = dn[sel];
  assign o_err  = er[sel];

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the glyph until a terminal segment or the index limit.
  sg_t exp_q[$];
  int  exp_lat[$];
  bit  exp_err;

  task automatic model(input logic [3:0] dg, input int ms);
    logic prev = 1'b0;
    exp_q.delete();
    exp_lat.delete();
    exp_err = 0;
    for (int i = 0; i < ms; i++) begin
      sg_t s = rom[dg][i];
      exp_q.push_back(s);
      exp_lat.push_back((s.pen != prev) ? 2 + P : 2);
      prev = s.pen;
      if (i != 0 && !s.pen && s.ex == 0 && s.ey == 0) return;
      if (i == ms - 1) exp_err = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_glyph(input vec_t v);
    int t, trig, done_t, n, hold_left, pen_t, pause_left, exp_n, exp_e;
    bit first, fin;
    logic last_pen;
    model(v.dg, v.b ? MS_B : MS_A);
    exp_n = (v.n < 0) ? exp_q.size() : v.n;
    exp_e = (v.n < 0) ? int'(exp_err) : v.e;
    @(negedge clk);
    sel = v.b; digit = v.dg; start = 1'b1;
    t = 0; trig = 0;
    @(negedge clk);
    start = 1'b0; t = 1;
    chk("fetch_busy", o_busy, 1);
    chk("fetch_idx", o_ix, 0);
    chk("fetch_glyph", o_gs, v.dg);
    chk("fetch_rom_en", o_re, 1);
    chk("err_cleared", o_err, 0);
    n = 0; done_t = -1; first = 1; hold_left = -1; pen_t = -100;
    pause_left = 0; fin = 0; last_pen = o_pen;
    for (int c = 0; c < 4000; c++) begin
      move_done = 1'b0;
      cmd_ready = 1'b0;
      if (o_pen !== last_pen) begin pen_t = t; last_pen = o_pen; end
      if (o_done) begin
        chk("cmd_count", n, exp_n);
        chk("err_at_done", o_err, exp_e);
        chk("pen_at_fin", o_pen, 0);
        @(negedge clk);
        chk("idle_after_done", o_busy, 0);
        chk("single_done", o_done, 0);
        chk("err_sticky", o_err, exp_e);
        fin = 1;
        break;
      end
      if (pause_left > 0) begin
        chk("pause_no_fetch", o_re, 0);
        chk("pause_pen_held", o_pen, exp_q[n-1].pen);
        chk("pause_busy", o_busy, 1);
      end
      if (o_cv) begin
        if (n >= exp_q.size()) begin chk("extra_cmd", n, exp_q.size() - 1); break; end
        if (first) begin
          chk("issue_latency", t - trig, exp_lat[n]);
          if (exp_lat[n] > 2) chk("settle_gap", t - pen_t, P);
          chk("pen_at_issue", o_pen, exp_q[n].pen);
          first = 0;
          if (n == v.hold) hold_left = 10;
        end
        chk("cmd_coords", o_cmd, {exp_q[n].sx, exp_q[n].sy, exp_q[n].ex, exp_q[n].ey});
        if (hold_left > 0) hold_left--;
        else cmd_ready = ($urandom_range(99) < v.rdy);
        if (cmd_ready) begin n++; first = 1; done_t = t + 1 + v.dly; end
      end
      if (t == done_t) begin
        move_done = 1'b1; trig = t;
        if (n - 1 == v.abrt) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0; move_done = 1'b0;
          chk("abort_idle", o_busy, 0);
          chk("abort_pen", o_pen, 0);
          chk("abort_no_done", o_done, 0);
          chk("abort_cmd_count", n, v.abrt + 1);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          chk("restart_busy", o_busy, 1);
          chk("restart_idx", o_ix, 0);
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_in_fetch", o_busy, 0);
          move_done = 1'b1;
          @(negedge clk);
          move_done = 1'b0;
          chk("idle_ignores_done", o_busy, 0);
          fin = 1;
          break;
        end
        if (n - 1 == v.pz) pause_left = 6;
      end
`ifdef STROKE_SEQ_PAUSE_EN
      pause = (pause_left > 0);
`endif
      if (pause_left > 0) begin pause_left--; trig = t + 1; end
      @(negedge clk);
      t++;
    end
    move_done = 1'b0; cmd_ready = 1'b0;
`ifdef STROKE_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    if (!fin) begin
      total++; bad++;
      $display("FAIL glyph_end: digit %0d never finished cleanly, %0d of %0d commands", v.dg, n, exp_n);
      do_reset();
    end
  endtask

  vec_t tbl[$];

  initial begin
    for (int d = 0; d < 16; d++)
      for (int i = 0; i < 32; i++) rom[d][i] = '0;
    rom[3][0] = '{8'd0,   8'd0,   8'd60,  8'd40,  1'b0};
    rom[3][1] = '{8'd60,  8'd40,  8'd60,  8'd120, 1'b1};
    rom[3][2] = '{8'd60,  8'd120, 8'd120, 8'd120, 1'b1};
    rom[3][3] = '{8'd120, 8'd120, 8'd180, 8'd120, 1'b1};
    rom[3][4] = '{8'd180, 8'd120, 8'd180, 8'd80,  1'b1};
    rom[3][5] = '{8'd180, 8'd80,  8'd120, 8'd80,  1'b1};
    rom[3][6] = '{8'd120, 8'd80,  8'd180, 8'd40,  1'b1};
    rom[3][7] = '{8'd180, 8'd40,  8'd0,   8'd0,   1'b0};
    rom[1][0] = '{8'd10,  8'd10,  8'd0,   8'd0,   1'b0};
    for (int i = 0; i < 32; i++)
      rom[9][i] = '{8'(i * 7), 8'd5, 8'(i * 7 + 3), 8'd9, 1'b1};
    for (int d = 4; d < 9; d++) begin
      int len = $urandom_range(12, 2);
      for (int i = 0; i < len; i++) begin
        sg_t s;
        s.sx = 8'($urandom); s.sy = 8'($urandom);
        s.ex = 8'($urandom); s.ey = 8'($urandom);
        s.pen = 1'($urandom);
        if (i == len - 1) begin s.pen = 0; s.ex = 0; s.ey = 0; end
        else if (i > 0 && !s.pen && s.ex == 0 && s.ey == 0) s.ex = 8'd1;
        rom[d][i] = s;
      end
    end

    //              dg  b  rdy dly hold abrt pz  n   e
    tbl.push_back('{4'd3, 0, 100, 2, -1, -1, -1,  8, 0});
    tbl.push_back('{4'd3, 0, 100, 2,  2, -1, -1,  8, 0});
    tbl.push_back('{4'd3, 0, 100, 2, -1,  3, -1,  4, 0});
    tbl.push_back('{4'd9, 1, 100, 1, -1, -1, -1,  4, 1});
    tbl.push_back('{4'd1, 1, 100, 0, -1, -1, -1,  2, 0});
    tbl.push_back('{4'd9, 0, 100, 0, -1, -1, -1, 32, 1});
    tbl.push_back('{4'd1, 0,  50, 3, -1, -1, -1,  2, 0});
`ifdef STROKE_SEQ_PAUSE_EN
    tbl.push_back('{4'd3, 0, 100, 2, -1, -1,  1,  8, 0});
`endif
    for (int r = 0; r < 8; r++)
      tbl.push_back('{4'($urandom_range(8, 4)), 1'($urandom_range(1, 0)),
                      $urandom_range(100, 40), $urandom_range(3, 0), -1, -1, -1, -1, 0});

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset_outputs", {gs[k], ix[k], re[k], cv[k], csx[k], csy[k], cex[k], cey[k],
                            pn[k], bz[k], dn[k], er[k]}, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_glyph(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
